// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational MIPS ALU among NREQ requesters.
// Operands are latched at grant, the ALU is driven for one cycle, and result/zero are returned registered.
module alu_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int OPSEL_W = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [32*NREQ-1:0]        req_opA,
  input  logic [32*NREQ-1:0]        req_opB,
  input  logic [OPSEL_W*NREQ-1:0]   req_opSel,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [31:0]               resp_result,
  output logic                      resp_zero,
  output logic                      resp_err,
  output logic [31:0]               alu_opA,
  output logic [31:0]               alu_opB,
  output logic [OPSEL_W-1:0]        alu_opSel,
  input  logic [31:0]               alu_result,
  input  logic                      alu_zero
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Op codes with no ALU function, or a divide by zero, yield an undefined result.
  function automatic logic op_undefined(input logic [3:0] op, input logic [31:0] b);
    op_undefined = (op == 4'b1110) || (op == 4'b1111) ||
                   ((op == 4'b0101) && (b == 32'h0000_0000));
  endfunction

  // Returns {found, index} of the first valid requester after 'last', wrapping.
  function automatic logic [IW:0] pick_grant(input logic [NREQ-1:0] valid,
                                             input logic [IW-1:0]   last);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    pick_grant = {found, idx};
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [IW-1:0]        last_grant_r;
  logic [IW-1:0]        gidx_r;
  logic [IW-1:0]        grant_s;
  logic                 found_s;
  logic                 handshake_s;
  logic [31:0]          opa_r;
  logic [31:0]          opb_r;
  logic [OPSEL_W-1:0]   opsel_r;
  logic                 err_r;
  logic [31:0]          result_r;
  logic                 zero_r;
  logic [31:0]          sel_a_s;
  logic [31:0]          sel_b_s;
  logic [OPSEL_W-1:0]   sel_op_s;

  assign {found_s, grant_s} = pick_grant(req_valid, last_grant_r);
  assign handshake_s        = (state_r == IDLE) && found_s;

  // Operand mux for the requester currently chosen by the search.
  always_comb begin
    sel_a_s  = 32'h0000_0000;
    sel_b_s  = 32'h0000_0000;
    sel_op_s = {OPSEL_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s  = sel_a_s  | (req_opA[32*i +: 32]           & {32{grant_s == IW'(i)}});
      sel_b_s  = sel_b_s  | (req_opB[32*i +: 32]           & {32{grant_s == IW'(i)}});
      sel_op_s = sel_op_s | (req_opSel[OPSEL_W*i +: OPSEL_W] & {OPSEL_W{grant_s == IW'(i)}});
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (resp_ready[gidx_r]) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake strobes; both are suppressed while reset is asserted.
  always_comb begin
    req_ready  = {NREQ{1'b0}};
    resp_valid = {NREQ{1'b0}};
    if (handshake_s && !rst) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    if ((state_r == RESP) && !rst) begin
      resp_valid[gidx_r] = 1'b1;
    end else begin
      resp_valid = {NREQ{1'b0}};
    end
  end

  // State register, grant capture and operand latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= IW'(NREQ - 1);
      gidx_r       <= {IW{1'b0}};
      opa_r        <= 32'h0000_0000;
      opb_r        <= 32'h0000_0000;
      opsel_r      <= {OPSEL_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      if (handshake_s) begin
        last_grant_r <= grant_s;
        gidx_r       <= grant_s;
        opa_r        <= sel_a_s;
        opb_r        <= sel_b_s;
        opsel_r      <= sel_op_s;
        err_r        <= op_undefined(sel_op_s[3:0], sel_b_s);
      end
    end
  end

  // Result capture at the end of EXEC; undefined ops discard the ALU output.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= 32'h0000_0000;
      zero_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      result_r <= err_r ? 32'h0000_0000 : alu_result;
      zero_r   <= err_r ? 1'b1 : alu_zero;
    end
  end

  assign alu_opA     = opa_r;
  assign alu_opB     = opb_r;
  assign alu_opSel   = opsel_r;
  assign resp_result = result_r;
  assign resp_zero   = zero_r;
  assign resp_err    = err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached to the alu_* port.
module tb_alu_share_arbiter;
  localparam int NREQ    = 2;
  localparam int OPSEL_W = 9;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [32*NREQ-1:0]      req_opA;
  logic [32*NREQ-1:0]      req_opB;
  logic [OPSEL_W*NREQ-1:0] req_opSel;
  logic [NREQ-1:0]         resp_valid;
  logic [NREQ-1:0]         resp_ready;
  logic [31:0]             resp_result;
  logic                    resp_zero;
  logic                    resp_err;
  logic [31:0]             alu_opA;
  logic [31:0]             alu_opB;
  logic [OPSEL_W-1:0]      alu_opSel;
  logic [31:0]             alu_result;
  logic                    alu_zero;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NREQ(NREQ), .OPSEL_W(OPSEL_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_opSel(req_opSel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opSel(alu_opSel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: div by zero and unknown ops return garbage so forcing is observable.
  always_comb begin
    case (alu_opSel[3:0])
      4'b0010: alu_result = alu_opA + alu_opB;
      4'b0110: alu_result = alu_opA - alu_opB;
      4'b0101: alu_result = (alu_opB == 32'h0) ? 32'hDEAD_BEEF :
                            {16'(alu_opA % alu_opB), 16'(alu_opA / alu_opB)};
      4'b1011: alu_result = alu_opA << alu_opSel[8:4];
      default: alu_result = 32'hFFFF_FFFF;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [8:0] sel, input logic v);
    req_opA[32*i +: 32]             = a;
    req_opB[32*i +: 32]             = b;
    req_opSel[OPSEL_W*i +: OPSEL_W] = sel;
    req_valid[i]                    = v;
  endtask

  // Full transaction: grant in IDLE, operands on the ALU in EXEC, response two cycles later.
  task automatic run_op(input string tag, input int gi, input logic [31:0] a, input logic [31:0] b,
                        input logic [8:0] sel, input logic [31:0] er, input logic ez,
                        input logic ee, input logic drop);
    set_req(gi, a, b, sel, 1'b1);
    @(negedge clk);
    check({tag, " grant"}, 32'(req_ready), 32'(1 << gi));
    @(posedge clk);
    #1;
    if (drop) req_valid[gi] = 1'b0;
    @(negedge clk);
    check({tag, " exec no valid"}, 32'(resp_valid), 32'h0);
    check({tag, " alu_opA"}, alu_opA, a);
    check({tag, " alu_opB"}, alu_opB, b);
    check({tag, " alu_opSel"}, 32'(alu_opSel), 32'(sel));
    @(negedge clk);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'(1 << gi));
    check({tag, " result"}, resp_result, er);
    check({tag, " zero"}, 32'(resp_zero), 32'(ez));
    check({tag, " err"}, 32'(resp_err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    req_opA    = '0;
    req_opB    = '0;
    req_opSel  = '0;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst resp_valid", 32'(resp_valid), 32'h0);
    check("rst result", resp_result, 32'h0);
    check("rst zero", 32'(resp_zero), 32'h0);
    check("rst err", 32'(resp_err), 32'h0);
    check("rst alu_opSel", 32'(alu_opSel), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 2'b00;

    run_op("add", 0, 32'd5, 32'd7, 9'h002, 32'd12, 1'b0, 1'b0, 1'b1);

    // Reset again so the contention rotation starts from requester 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 32'd9, 32'd9, 9'h006, 1'b1);
    set_req(1, 32'd3, 32'd1, 9'h006, 1'b1);
    run_op("c0a", 0, 32'd9, 32'd9, 9'h006, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("c1a", 1, 32'd3, 32'd1, 9'h006, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("c0b", 0, 32'd9, 32'd9, 9'h006, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("c1b", 1, 32'd3, 32'd1, 9'h006, 32'd2, 1'b0, 1'b0, 1'b1);

    // Back-pressure on requester 0 while requester 1 keeps asking.
    set_req(0, 32'd1, 32'd2, 9'h002, 1'b1);
    set_req(1, 32'd3, 32'd1, 9'h006, 1'b1);
    @(negedge clk);
    check("bp grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    resp_ready   = 2'b00;
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp resp_valid", 32'(resp_valid), 32'h1);
      check("bp result", resp_result, 32'd3);
      check("bp zero", 32'(resp_zero), 32'h0);
      check("bp req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    resp_ready = 2'b11;
    @(negedge clk);
    check("bp release valid", 32'(resp_valid), 32'h1);
    run_op("bp next", 1, 32'd3, 32'd1, 9'h006, 32'd2, 1'b0, 1'b0, 1'b1);

    run_op("div0", 0, 32'd5, 32'd0, 9'h005, 32'h0, 1'b1, 1'b1, 1'b1);
    run_op("op1111", 0, 32'd3, 32'd4, 9'h00F, 32'h0, 1'b1, 1'b1, 1'b1);
    run_op("div", 0, 32'd100, 32'd7, 9'h005, 32'h0002_000E, 1'b0, 1'b0, 1'b1);
    run_op("op1110", 1, 32'd8, 32'd8, 9'h00E, 32'h0, 1'b1, 1'b1, 1'b1);
    run_op("sll", 0, 32'd1, 32'd0, 9'h04B, 32'h0000_0010, 1'b0, 1'b0, 1'b1);

    // Reset during EXEC.
    set_req(0, 32'd5, 32'd7, 9'h002, 1'b1);
    @(negedge clk);
    check("rx grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check("rx rst resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx resp_valid", 32'(resp_valid), 32'h0);
    check("rx result", resp_result, 32'h0);
    check("rx alu_opA", alu_opA, 32'h0);
    check("rx alu_opSel", 32'(alu_opSel), 32'h0);
    @(negedge clk);
    check("rx later resp_valid", 32'(resp_valid), 32'h0);

    // Both requesters valid: requester 0 must win; then reset during RESP.
    @(posedge clk);
    #1;
    set_req(0, 32'd4, 32'd4, 9'h006, 1'b1);
    set_req(1, 32'd8, 32'd1, 9'h006, 1'b1);
    @(negedge clk);
    check("rr grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    resp_ready   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rr resp_valid", 32'(resp_valid), 32'h1);
    check("rr zero", 32'(resp_zero), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rr rst resp_valid", 32'(resp_valid), 32'h0);
    check("rr rst req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 2'b11;
    set_req(0, 32'd4, 32'd4, 9'h006, 1'b1);
    @(negedge clk);
    check("rr after resp_valid", 32'(resp_valid), 32'h0);
    check("rr after zero", 32'(resp_zero), 32'h0);
    check("rr after err", 32'(resp_err), 32'h0);
    check("rr after grant", 32'(req_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
